// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decode-side fields, operand reads, flush, writeback
// mirror, and the registered EX-side outputs plus stall/bubble status.
interface id_ex_stage_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
);
   logic             id_valid;
   logic [XLEN-1:0]  id_pc;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       id_rd;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic [XLEN-1:0]  id_imm;
   logic [7:0]       id_ctrl;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic             flush;
   logic             wb_write;
   logic [4:0]       wb_address;
   logic [XLEN-1:0]  wb_data;

   logic             ex_valid;
   logic [XLEN-1:0]  ex_pc;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic [4:0]       ex_rd;
   logic [XLEN-1:0]  ex_imm;
   logic [7:0]       ex_ctrl;
   logic [XLEN-1:0]  ex_op1;
   logic [XLEN-1:0]  ex_op2;
   logic             stall_out;
   logic [CNT_W-1:0] bubble_count;

   // Pipeline register side.
   modport slave (
      input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_imm, id_ctrl, rs1_data, rs2_data, flush,
             wb_write, wb_address, wb_data,
      output ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_ctrl,
             ex_op1, ex_op2, stall_out, bubble_count
   );

   // Decode/control side.
   modport master (
      output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
             id_imm, id_ctrl, rs1_data, rs2_data, flush,
             wb_write, wb_address, wb_data,
      input  ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_ctrl,
             ex_op1, ex_op2, stall_out, bubble_count
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating bubble counter.
// Optional feature: define ID_EX_WB_BYPASS_EN to forward the writeback port
// into the captured operands (x0 still reads as zero).
module id_ex_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic          clock_debug,
   input  logic          reset,
   id_ex_stage_if.slave  bus
);

   logic             ex_valid_q, ex_valid_d;
   logic [XLEN-1:0]  ex_pc_q,    ex_pc_d;
   logic [4:0]       ex_rs1_q,   ex_rs1_d;
   logic [4:0]       ex_rs2_q,   ex_rs2_d;
   logic [4:0]       ex_rd_q,    ex_rd_d;
   logic [XLEN-1:0]  ex_imm_q,   ex_imm_d;
   logic [7:0]       ex_ctrl_q,  ex_ctrl_d;
   logic [XLEN-1:0]  ex_op1_q,   ex_op1_d;
   logic [XLEN-1:0]  ex_op2_q,   ex_op2_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;

   logic             hazard_c;
   logic             bubble_c;
   logic [XLEN-1:0]  op1_c;
   logic [XLEN-1:0]  op2_c;

   // Load in EX whose destination is read by the live decode instruction.
   always_comb begin
      hazard_c = ex_valid_q & ex_ctrl_q[1] & (ex_rd_q != 5'd0) & bus.id_valid &
                 ((bus.id_uses_rs1 & (bus.id_rs1 == ex_rd_q)) |
                  (bus.id_uses_rs2 & (bus.id_rs2 == ex_rd_q)));
      bubble_c = bus.flush | hazard_c;
   end

   // Flush kills the decode instruction, so it never needs to be held.
   assign bus.stall_out = hazard_c & ~bus.flush & ~reset;

   // Operand selection: x0 reads zero, otherwise (optionally) writeback bypass.
   always_comb begin
      op1_c = bus.rs1_data;
      op2_c = bus.rs2_data;
`ifdef ID_EX_WB_BYPASS_EN
      if (bus.wb_write && (bus.wb_address != 5'd0) && (bus.wb_address == bus.id_rs1))
         op1_c = bus.wb_data;
      if (bus.wb_write && (bus.wb_address != 5'd0) && (bus.wb_address == bus.id_rs2))
         op2_c = bus.wb_data;
`endif
      if (bus.id_rs1 == 5'd0) op1_c = '0;
      if (bus.id_rs2 == 5'd0) op2_c = '0;
   end

`ifndef ID_EX_WB_BYPASS_EN
   logic unused_wb;
   assign unused_wb = ^{bus.wb_write, bus.wb_address, bus.wb_data};
`endif

   // Next EX register contents: bubble (all zero) or the decode fields.
   always_comb begin
      ex_valid_d = 1'b0;
      ex_pc_d    = '0;
      ex_rs1_d   = '0;
      ex_rs2_d   = '0;
      ex_rd_d    = '0;
      ex_imm_d   = '0;
      ex_ctrl_d  = '0;
      ex_op1_d   = '0;
      ex_op2_d   = '0;
      cnt_d      = cnt_q;
      if (!bubble_c) begin
         ex_valid_d = bus.id_valid;
         ex_pc_d    = bus.id_pc;
         ex_rs1_d   = bus.id_rs1;
         ex_rs2_d   = bus.id_rs2;
         ex_rd_d    = bus.id_rd;
         ex_imm_d   = bus.id_imm;
         ex_ctrl_d  = bus.id_valid ? bus.id_ctrl : 8'd0;
         ex_op1_d   = op1_c;
         ex_op2_d   = op2_c;
      end
      if (bubble_c && bus.id_valid && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // EX register and counter, synchronous reset.
   always_ff @(posedge clock_debug) begin
      if (reset) begin
         ex_valid_q <= 1'b0;
         ex_pc_q    <= '0;
         ex_rs1_q   <= '0;
         ex_rs2_q   <= '0;
         ex_rd_q    <= '0;
         ex_imm_q   <= '0;
         ex_ctrl_q  <= '0;
         ex_op1_q   <= '0;
         ex_op2_q   <= '0;
         cnt_q      <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_pc_q    <= ex_pc_d;
         ex_rs1_q   <= ex_rs1_d;
         ex_rs2_q   <= ex_rs2_d;
         ex_rd_q    <= ex_rd_d;
         ex_imm_q   <= ex_imm_d;
         ex_ctrl_q  <= ex_ctrl_d;
         ex_op1_q   <= ex_op1_d;
         ex_op2_q   <= ex_op2_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.ex_valid     = ex_valid_q;
   assign bus.ex_pc        = ex_pc_q;
   assign bus.ex_rs1       = ex_rs1_q;
   assign bus.ex_rs2       = ex_rs2_q;
   assign bus.ex_rd        = ex_rd_q;
   assign bus.ex_imm       = ex_imm_q;
   assign bus.ex_ctrl      = ex_ctrl_q;
   assign bus.ex_op1       = ex_op1_q;
   assign bus.ex_op2       = ex_op2_q;
   assign bus.bubble_count = cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC, immediate and operands.
REQ-002 SHALL have parameter CNT_W, default 16, width of bubble counter.
REQ-003 clock_debug  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 id_valid  input  1  decode slot holds a live instruction.
REQ-006 id_pc  input  XLEN  PC of decode instruction.
REQ-007 id_rs1, id_rs2, id_rd  input  5 each  source/destination register indices.
REQ-008 id_uses_rs1, id_uses_rs2  input  1 each  instruction actually reads that source.
REQ-009 id_imm  input  XLEN  decoded immediate.
REQ-010 id_ctrl  input  8  control bundle; bit0 reg_write, bit1 mem_read, bit2 mem_write, bits7:3 ALU op passthrough.
REQ-011 rs1_data, rs2_data  input  XLEN  register-file read ports 1/2.
REQ-012 flush  input  1  taken branch/jump resolved in EX; kill decode instruction.
REQ-013 wb_write, wb_address, wb_data  input  1/5/XLEN  writeback port mirror (same values driven to register-file write port).
REQ-014 ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_ctrl  output  registered copies of id_* fields.
REQ-015 ex_op1, ex_op2  output  XLEN  registered operands.
REQ-016 stall_out  output  1  combinational; hold PC and IF/ID this cycle.
REQ-017 bubble_count  output  CNT_W  registered count of bubbles inserted.

Function
REQ-018 Load-use hazard SHALL be: ex_valid & ex_ctrl[1] & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-019 stall_out SHALL equal hazard & ~flush.
REQ-020 Each edge, flush=1: EX register loads bubble (ex_valid=0, ex_ctrl=0, other fields don't-care but held to 0).
REQ-021 Else hazard=1: EX register loads bubble; decode instruction held upstream, re-presented next cycle.
REQ-022 Else: EX register loads all id_* fields, ex_valid=id_valid; id_valid=0 SHALL force ex_ctrl=0.
REQ-023 Stall SHALL last exactly one cycle per load (after bubble, ex_valid=0 so hazard clears).
REQ-024 id_rs1==0 SHALL capture ex_op1=0 regardless of rs1_data; same for rs2/ex_op2.
REQ-025 Otherwise ex_op1=rs1_data, ex_op2=rs2_data (subject to REQ-034).
REQ-026 Latency id_* -> ex_* SHALL be one clock_debug cycle.
REQ-027 bubble_count SHALL increment by 1 on every edge loading a bubble due to flush or hazard while id_valid=1; saturates at all-ones, no wrap.
REQ-028 Simultaneous flush and hazard: flush wins, one increment, stall_out=0.

Reset
REQ-029 reset=1 at edge: ex_valid=0, ex_ctrl=0, ex_pc/ex_imm/ex_op1/ex_op2=0, ex_rs1/ex_rs2/ex_rd=0, bubble_count=0.
REQ-030 During reset, stall_out SHALL be 0 (ex_valid=0 after first reset edge); reset overrides flush/hazard.
REQ-031 Reset mid-stall SHALL discard the pending bubble; no count increment on reset edge.

Configuration
REQ-032 Macro ID_EX_WB_BYPASS_EN selects writeback bypass at capture.
REQ-033 Without macro: operands per REQ-024/025 only; wb_* inputs unused.
REQ-034 With macro: if wb_write & wb_address!=0 & wb_address==id_rs1, ex_op1=wb_data (same for rs2/ex_op2); x0 rule REQ-024 still has priority.

Verification
REQ-035 Reset: reset=1 two cycles with id_valid=1 -> ex_valid=0, ex_ctrl=0, bubble_count=0, stall_out=0.
REQ-036 Pass-through: id_pc=0x100, id_rd=5, id_ctrl=0x01, rs1_data=0xDEAD -> next edge ex_pc=0x100, ex_rd=5, ex_op1=0xDEAD, ex_valid=1.
REQ-037 Load-use: EX holds lw x7 (ctrl=0x03); ID add rs1=7 uses_rs1=1 -> stall_out=1, next edge ex_valid=0, bubble_count=1; following edge add captured, stall_out=0.
REQ-038 Flush+hazard same cycle -> stall_out=0, bubble, bubble_count +1 only.
REQ-039 x0: id_rs1=0, rs1_data=0x1234 -> ex_op1=0; with ID_EX_WB_BYPASS_EN, wb_write=1, wb_address=3, wb_data=0xBEEF, id_rs2=3, rs2_data=0 -> ex_op2=0xBEEF; without macro ex_op2=0.
REQ-040 Saturation: CNT_W=2, five flushes with id_valid=1 -> bubble_count=3.
